// File: rtl/pwm_duty_scheduler_if.sv
// Target-level request channel for pwm_duty_scheduler.
//   tgt_valid   : requester has a target level on tgt_level
//   tgt_level   : requested duty level (values above STEPS get clamped)
//   tgt_ready   : scheduler can accept a target this cycle
//   tgt_clamped : one-cycle pulse after an accepted target exceeded STEPS
interface pwm_duty_scheduler_if #(
  parameter int unsigned LVL_W = 4
) ();
  logic             tgt_valid;
  logic [LVL_W-1:0] tgt_level;
  logic             tgt_ready;
  logic             tgt_clamped;

  modport master (
    output tgt_valid,
    output tgt_level,
    input  tgt_ready,
    input  tgt_clamped
  );

  modport slave (
    input  tgt_valid,
    input  tgt_level,
    output tgt_ready,
    output tgt_clamped
  );
endinterface

// File: rtl/pwm_duty_scheduler.sv
// Sequencing controller for pwm_generator: owns its increase/decrease/reset
// inputs, keeps a shadow duty level and walks it one step at a time toward
// button requests or an accepted target, with a settle gap after every pulse.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   btn_up, btn_down    : synchronous button levels, rising edge = one step
//   tgt                 : target-level valid/ready channel (slave side)
//   increase_duty       : one-cycle +1 step pulse to the generator
//   decrease_duty       : one-cycle -1 step pulse to the generator
//   gen_reset           : active-high generator reset
//   level               : shadow duty level
//   busy                : FSM is not idle
module pwm_duty_scheduler #(
  parameter int unsigned STEPS       = 10,
  parameter int unsigned LVL_W       = 4,
  parameter int unsigned RESET_LEVEL = 5,
  parameter int unsigned GAP_CYCLES  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_up,
  input  logic                 btn_down,
  pwm_duty_scheduler_if.slave  tgt,
  output logic                 increase_duty,
  output logic                 decrease_duty,
  output logic                 gen_reset,
  output logic [LVL_W-1:0]     level,
  output logic                 busy
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [LVL_W-1:0] STEPS_L = LVL_W'(STEPS);
  localparam logic [LVL_W-1:0] RST_L   = LVL_W'(RESET_LEVEL);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_STEP, S_GAP} state_t;

  state_t             state, state_n;
  logic [LVL_W-1:0]   level_n, target, target_n, tgt_sat;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic               dir_up, dir_up_n;
  logic               btn_up_q, btn_down_q;
  logic               pend_up, pend_down, pend_up_n, pend_down_n;
  logic               svc_up, svc_down, accept, clamped_n;
  logic               p_up, p_dn;
  logic               inc_n, dec_n, busy_n, gen_reset_n, ready_n;

  assign accept  = tgt.tgt_valid & tgt.tgt_ready;
  assign tgt_sat = (tgt.tgt_level > STEPS_L) ? STEPS_L : tgt.tgt_level;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_INIT;
    else        state <= state_n;
  end

  // Next-state and datapath next values
  always_comb begin
    state_n   = state;
    target_n  = target;
    dir_up_n  = dir_up;
    gap_cnt_n = gap_cnt;
    svc_up    = 1'b0;
    svc_down  = 1'b0;
    clamped_n = 1'b0;
    level_n   = level;
    unique case (state)
      S_INIT: state_n = S_IDLE;
      S_IDLE: begin
        if (pend_up) begin
          // A request at the limit is consumed without moving
          svc_up = 1'b1;
          if (level != STEPS_L) begin
            target_n = level + LVL_W'(1);
            dir_up_n = 1'b1;
            state_n  = S_STEP;
          end
        end else if (pend_down) begin
          svc_down = 1'b1;
          if (level != '0) begin
            target_n = level - LVL_W'(1);
            dir_up_n = 1'b0;
            state_n  = S_STEP;
          end
        end else if (accept) begin
          target_n  = tgt_sat;
          clamped_n = tgt.tgt_level > STEPS_L;
          if (tgt_sat != level) begin
            dir_up_n = tgt_sat > level;
            state_n  = S_STEP;
          end
        end
      end
      S_STEP: begin
        level_n   = dir_up ? level + LVL_W'(1) : level - LVL_W'(1);
        gap_cnt_n = GAP_W'(GAP_CYCLES);
        state_n   = S_GAP;
      end
      S_GAP: begin
        // Last gap cycle: chain straight into the next step if still off target
        if (gap_cnt <= GAP_W'(1)) begin
          gap_cnt_n = '0;
          if (level != target) begin
            dir_up_n = target > level;
            state_n  = S_STEP;
          end else begin
            state_n  = S_IDLE;
          end
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  // One-deep button pending flags; opposite requests cancel each other
  always_comb begin
    p_up        = svc_up   ? 1'b0 : (pend_up   | (btn_up   & ~btn_up_q));
    p_dn        = svc_down ? 1'b0 : (pend_down | (btn_down & ~btn_down_q));
    pend_up_n   = p_up & ~p_dn;
    pend_down_n = p_dn & ~p_up;
  end

  // Output decode from the next state, registered below
  always_comb begin
    inc_n       = (state_n == S_STEP) &  dir_up_n;
    dec_n       = (state_n == S_STEP) & ~dir_up_n;
    busy_n      = state_n != S_IDLE;
    gen_reset_n = state_n == S_INIT;
    ready_n     = (state_n == S_IDLE) & ~pend_up_n & ~pend_down_n;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      level           <= RST_L;
      target          <= RST_L;
      dir_up          <= 1'b0;
      gap_cnt         <= '0;
      pend_up         <= 1'b0;
      pend_down       <= 1'b0;
      btn_up_q        <= 1'b1;
      btn_down_q      <= 1'b1;
      increase_duty   <= 1'b0;
      decrease_duty   <= 1'b0;
      busy            <= 1'b0;
      gen_reset       <= 1'b1;
      tgt.tgt_ready   <= 1'b0;
      tgt.tgt_clamped <= 1'b0;
    end else begin
      level           <= level_n;
      target          <= target_n;
      dir_up          <= dir_up_n;
      gap_cnt         <= gap_cnt_n;
      pend_up         <= pend_up_n;
      pend_down       <= pend_down_n;
      btn_up_q        <= btn_up;
      btn_down_q      <= btn_down;
      increase_duty   <= inc_n;
      decrease_duty   <= dec_n;
      busy            <= busy_n;
      gen_reset       <= gen_reset_n;
      tgt.tgt_ready   <= ready_n;
      tgt.tgt_clamped <= clamped_n;
    end
  end

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed bench for pwm_duty_scheduler (STEPS=10, RESET_LEVEL=5, GAP_CYCLES=4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pwm_duty_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       increase_duty, decrease_duty, gen_reset, busy;
  logic [3:0] level;

  pwm_duty_scheduler_if #(.LVL_W(4)) tgt_if ();

  pwm_duty_scheduler #(
    .STEPS(10), .LVL_W(4), .RESET_LEVEL(5), .GAP_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .tgt(tgt_if), .increase_duty(increase_duty), .decrease_duty(decrease_duty),
    .gen_reset(gen_reset), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse bookkeeping, sampled mid-cycle
  int cyc = 0;
  int last_p = -1;
  int min_gap = 1000;
  int inc_total = 0;
  int dec_total = 0;
  int both_hi = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (increase_duty && decrease_duty) both_hi = 1;
    if (increase_duty || decrease_duty) begin
      if (last_p >= 0 && (cyc - last_p) < min_gap) min_gap = cyc - last_p;
      last_p = cyc;
    end
    if (increase_duty) inc_total = inc_total + 1;
    if (decrease_duty) dec_total = dec_total + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset for 3 cycles, release, and land in the first IDLE cycle
  task automatic do_reset();
    reset = 1'b0;
    tick(3);
    chk_eq("rst_gen_reset", 32'(gen_reset), 32'd1);
    chk_eq("rst_level", 32'(level), 32'd5);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_ready", 32'(tgt_if.tgt_ready), 32'd0);
    chk_eq("rst_inc", 32'(increase_duty), 32'd0);
    reset = 1'b1;
    chk_eq("init_gen_reset", 32'(gen_reset), 32'd1);
    tick();
    chk_eq("idle_gen_reset", 32'(gen_reset), 32'd0);
    chk_eq("idle_ready", 32'(tgt_if.tgt_ready), 32'd1);
    chk_eq("idle_busy", 32'(busy), 32'd0);
    chk_eq("idle_level", 32'(level), 32'd5);
  endtask

  int i0, d0;

  initial begin
    tgt_if.tgt_valid = 1'b0;
    tgt_if.tgt_level = 4'd0;

    // Reset
    do_reset();

    // Single up press, then a second press during the gap
    i0 = inc_total;
    btn_up = 1'b1;
    tick();                                   // n+1
    chk_eq("up_n1_inc", 32'(increase_duty), 32'd0);
    chk_eq("up_n1_ready", 32'(tgt_if.tgt_ready), 32'd0);
    btn_up = 1'b0;
    tick();                                   // n+2
    chk_eq("up_n2_inc", 32'(increase_duty), 32'd1);
    chk_eq("up_n2_busy", 32'(busy), 32'd1);
    chk_eq("up_n2_level", 32'(level), 32'd5);
    tick();                                   // n+3
    chk_eq("up_n3_inc", 32'(increase_duty), 32'd0);
    chk_eq("up_n3_level", 32'(level), 32'd6);
    btn_up = 1'b1;
    tick();                                   // n+4
    btn_up = 1'b0;
    tick(2);                                  // n+6
    chk_eq("up_n6_busy", 32'(busy), 32'd1);
    tick();                                   // n+7
    chk_eq("up_n7_busy", 32'(busy), 32'd0);
    chk_eq("up_n7_inc", 32'(increase_duty), 32'd0);
    tick();                                   // n+8
    chk_eq("up2_inc", 32'(increase_duty), 32'd1);
    tick();                                   // n+9
    chk_eq("up2_level", 32'(level), 32'd7);
    tick(4);                                  // n+13
    chk_eq("up2_ready", 32'(tgt_if.tgt_ready), 32'd1);
    chk_eq("up2_busy", 32'(busy), 32'd0);
    chk_eq("up_inc_count", 32'(inc_total - i0), 32'd2);

    // Target 2 from level 5
    do_reset();
    d0 = dec_total;
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_level = 4'd2;
    tick();                                   // t+1
    chk_eq("dn_t1_dec", 32'(decrease_duty), 32'd1);
    chk_eq("dn_t1_ready", 32'(tgt_if.tgt_ready), 32'd0);
    chk_eq("dn_t1_clamped", 32'(tgt_if.tgt_clamped), 32'd0);
    tgt_if.tgt_valid = 1'b0;
    tick(5);                                  // t+6
    chk_eq("dn_t6_dec", 32'(decrease_duty), 32'd1);
    chk_eq("dn_t6_level", 32'(level), 32'd4);
    tick(5);                                  // t+11
    chk_eq("dn_t11_dec", 32'(decrease_duty), 32'd1);
    chk_eq("dn_t11_level", 32'(level), 32'd3);
    tick(4);                                  // t+15
    chk_eq("dn_t15_ready", 32'(tgt_if.tgt_ready), 32'd0);
    chk_eq("dn_t15_level", 32'(level), 32'd2);
    tick();                                   // t+16
    chk_eq("dn_done_ready", 32'(tgt_if.tgt_ready), 32'd1);
    chk_eq("dn_done_busy", 32'(busy), 32'd0);
    chk_eq("dn_dec_count", 32'(dec_total - d0), 32'd3);

    // Clamp: target 15, then a press at the top limit
    do_reset();
    i0 = inc_total;
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_level = 4'd15;
    tick();                                   // t+1
    chk_eq("cl_t1_inc", 32'(increase_duty), 32'd1);
    chk_eq("cl_t1_clamped", 32'(tgt_if.tgt_clamped), 32'd1);
    tgt_if.tgt_valid = 1'b0;
    tick();                                   // t+2
    chk_eq("cl_t2_clamped", 32'(tgt_if.tgt_clamped), 32'd0);
    tick(24);                                 // t+26
    chk_eq("cl_level", 32'(level), 32'd10);
    chk_eq("cl_busy", 32'(busy), 32'd0);
    chk_eq("cl_inc_count", 32'(inc_total - i0), 32'd5);
    btn_up = 1'b1;
    tick();
    chk_eq("lim_pend_ready", 32'(tgt_if.tgt_ready), 32'd0);
    btn_up = 1'b0;
    tick();
    chk_eq("lim_inc", 32'(increase_duty), 32'd0);
    chk_eq("lim_ready", 32'(tgt_if.tgt_ready), 32'd1);
    chk_eq("lim_busy", 32'(busy), 32'd0);
    tick(5);
    chk_eq("lim_inc_count", 32'(inc_total - i0), 32'd5);
    chk_eq("lim_level", 32'(level), 32'd10);

    // Button pending while a target is offered: button goes first
    do_reset();
    i0 = inc_total;
    d0 = dec_total;
    btn_down = 1'b1;
    tick();                                   // +1
    chk_eq("pr_p1_ready", 32'(tgt_if.tgt_ready), 32'd0);
    btn_down = 1'b0;
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_level = 4'd8;
    tick();                                   // +2
    chk_eq("pr_p2_dec", 32'(decrease_duty), 32'd1);
    tick(5);                                  // +7
    chk_eq("pr_p7_ready", 32'(tgt_if.tgt_ready), 32'd1);
    chk_eq("pr_p7_level", 32'(level), 32'd4);
    tick();                                   // +8
    chk_eq("pr_p8_inc", 32'(increase_duty), 32'd1);
    tgt_if.tgt_valid = 1'b0;
    tick(20);                                 // +28
    chk_eq("pr_level", 32'(level), 32'd8);
    chk_eq("pr_busy", 32'(busy), 32'd0);
    chk_eq("pr_inc_count", 32'(inc_total - i0), 32'd4);
    chk_eq("pr_dec_count", 32'(dec_total - d0), 32'd1);

    // Simultaneous up and down edges cancel
    i0 = inc_total;
    d0 = dec_total;
    btn_up = 1'b1;
    btn_down = 1'b1;
    tick();
    chk_eq("cx_ready", 32'(tgt_if.tgt_ready), 32'd1);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(6);
    chk_eq("cx_busy", 32'(busy), 32'd0);
    chk_eq("cx_level", 32'(level), 32'd8);
    chk_eq("cx_pulses", 32'((inc_total - i0) + (dec_total - d0)), 32'd0);

    // Reset during the second gap of a 5 -> 9 move
    do_reset();
    i0 = inc_total;
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_level = 4'd9;
    tick();                                   // t+1
    tgt_if.tgt_valid = 1'b0;
    tick(7);                                  // t+8, inside second gap
    chk_eq("mr_level_mid", 32'(level), 32'd7);
    chk_eq("mr_busy_mid", 32'(busy), 32'd1);
    do_reset();
    tick(12);
    chk_eq("mr_inc_count", 32'(inc_total - i0), 32'd2);
    chk_eq("mr_level", 32'(level), 32'd5);
    chk_eq("mr_busy", 32'(busy), 32'd0);

    // Global pulse invariants
    chk_eq("inv_both_high", 32'(both_hi), 32'd0);
    chk_eq("inv_min_gap_ok", 32'(min_gap >= 5), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_scheduler.md
# pwm_duty_scheduler

Sequencing controller for `pwm_generator`. It owns the generator's `increase_duty`, `decrease_duty` and `reset` inputs and keeps a shadow copy of the duty level. Two requesters share the generator: manual up/down buttons, and a target-level port with a valid/ready handshake. Duty moves one step at a time, with step pulses spaced so the generator settles between them.

## Interface
- `STEPS`, 10: maximum duty level; levels run 0..STEPS.
- `LVL_W`, 4: level width; must satisfy 2^LVL_W > STEPS.
- `RESET_LEVEL`, 5: generator duty level after its reset (50 %).
- `GAP_CYCLES`, 10: idle cycles after each step pulse, ≥1.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `btn_up`  in  1  synchronous level; rising edge requests +1 step.
- `btn_down`  in  1  synchronous level; rising edge requests −1 step.
- `tgt_valid`  in  1  target request valid.
- `tgt_level`  in  LVL_W  requested duty level.
- `tgt_ready`  out  1  scheduler can accept a target.
- `tgt_clamped`  out  1  one-cycle pulse: the last accepted target exceeded STEPS.
- `increase_duty`  out  1  one-cycle step pulse to the generator.
- `decrease_duty`  out  1  one-cycle step pulse to the generator.
- `gen_reset`  out  1  active-high reset to the generator.
- `level`  out  LVL_W  shadow duty level.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- **FSM states:** INIT, IDLE, STEP, GAP. All outputs are registered or decoded from the state (Moore).
- **Reset (reset = 0 at an edge):**
  - state ← INIT; level ← RESET_LEVEL; target ← RESET_LEVEL.
  - Pending flags cleared; gap counter cleared.
  - Button history registers ← 1, so a button held through reset produces no edge.
  - gen_reset = 1; all other outputs 0.
- **INIT:** gen_reset stays high for this one cycle, then the FSM goes to IDLE.
- **Button edges:**
  - btn_x = 1 with previous sample 0 sets pend_x. This happens in every state, including during moves.
  - Further edges while pend_x is set are absorbed (one-deep).
  - If pend_up and pend_down would both be set, both are cleared (they cancel).
- **IDLE priority:**
  - A pending button is serviced first.
  - pend_up with level < STEPS → STEP(up); target ← level+1.
  - pend_down with level > 0 → STEP(down); target ← level−1.
  - A request at a limit is dropped and its pend flag is cleared; no pulse.
- **Target handshake:**
  - tgt_ready = 1 only in IDLE with no pend flag set.
  - Accept = tgt_valid & tgt_ready.
  - On accept, target ← min(tgt_level, STEPS), and tgt_clamped pulses the next cycle if tgt_level > STEPS.
  - target == level → remain IDLE, no pulse.
  - Otherwise → STEP, direction = sign(target − level).
- **STEP (1 cycle):**
  - Assert the matching increase_duty or decrease_duty.
  - level ±1 at the end of the cycle.
  - → GAP with counter = GAP_CYCLES.
- **GAP:** counter decrements each cycle. When the counter expires:
  - level ≠ target → STEP again, with no pass through IDLE.
  - otherwise → IDLE.
- **Invariants:**
  - level always stays in 0..STEPS; no wrap-around.
  - increase_duty and decrease_duty are never high together.
  - Pulses are never less than GAP_CYCLES+1 cycles apart.
- **Reset mid-operation:** the current STEP or GAP is aborted and the full reset behaviour above applies. The generator is re-reset, so level == RESET_LEVEL stays consistent with it.

## Timing
- **Reset release:** reset goes high before edge r. gen_reset is high through cycle r, then low. IDLE is entered at r+1; tgt_ready = 1 from r+1.
- **Button path:**
  - btn_up is sampled rising at edge n → pend_up is visible in cycle n+1.
  - The FSM is in STEP in cycle n+2: increase_duty high for that cycle only.
  - level updates, visible in cycle n+3.
  - GAP covers cycles n+3 .. n+2+GAP_CYCLES; IDLE is re-entered at n+3+GAP_CYCLES.
- **Target path:**
  - Accept at edge t → first pulse in cycle t+1.
  - A k-step move completes (IDLE re-entered) at t+1+k·(GAP_CYCLES+1).
- **Back-to-back targets:** after the final GAP, tgt_ready = 1 in the first IDLE cycle.

## Test plan
Parameters for all scenarios: STEPS = 10, RESET_LEVEL = 5, GAP_CYCLES = 4.

1. **Reset:** reset = 0 for 3 cycles, then release → gen_reset high for the reset cycles plus 1 more; level = 5; busy = 0; tgt_ready high 1 cycle after INIT.
2. **Single up press:** one btn_up press → exactly one increase_duty pulse, 2 cycles after the edge; level 5→6; busy for 5 cycles. A second press during the GAP is serviced afterward, giving level 7.
3. **Move down:** target 2 accepted → three decrease_duty pulses spaced 5 cycles apart; level 5→2; tgt_ready low until done.
4. **Clamp:** target 15 → target clamped to 10; tgt_clamped pulses once; five increase pulses. A btn_up press at level 10 → no pulse, pend cleared.
5. **Simultaneous requests:**
   - tgt_valid held together with a btn_down edge in IDLE → the button is serviced first (level 4) and the target is accepted afterward.
   - btn_up and btn_down rising in the same cycle → no pulse.
6. **Reset mid-move:** reset = 0 during the second GAP of a move 5→9 → pulses stop; level = 5; gen_reset reasserted; no stale pulse after release.
